// File: rtl/bp_fe_pkg.sv
// Shared frontend types: predictor update record, scheduler states and need decode.
`ifndef BP_FE_PRED_UPDATE_WIDTH
`define BP_FE_PRED_UPDATE_WIDTH
`define BP_FE_PRED_UPD_WIDTH(vaddr, tag, idx, bht_idx, ghist, row) \
    ((vaddr) + (tag) + (idx) + (bht_idx) + (ghist) + (row) + 6)
`endif

package bp_fe_pkg;

    // Flag bit positions within the low 6 bits of an update record
    localparam int unsigned flag_taken_lp   = 5;
    localparam int unsigned flag_ntaken_lp  = 4;
    localparam int unsigned flag_nonbr_lp   = 3;
    localparam int unsigned flag_src_btb_lp = 2;
    localparam int unsigned flag_is_br_lp   = 1;
    localparam int unsigned flag_is_jmp_lp  = 0;

    typedef struct packed {
        logic taken;
        logic ntaken;
        logic nonbr;
        logic src_btb;
        logic is_br;
        logic is_jmp;
    } bp_fe_pred_flags_s;

    typedef struct packed {
        logic [38:0]       tgt;
        logic [9:0]        tag;
        logic [5:0]        idx;
        logic [8:0]        bht_idx;
        logic [1:0]        ghist;
        logic [7:0]        bht_row;
        bp_fe_pred_flags_s flags;
    } bp_fe_pred_update_s;

    typedef enum logic {e_idle, e_issue} bp_fe_pred_sched_state_e;

    // Returns {need_btb, need_bht}
    function automatic logic [1:0] pred_upd_need(input logic is_redir,
                                                 input bp_fe_pred_flags_s f);
        logic need_btb;
        need_btb = (is_redir & f.taken) | (is_redir & f.nonbr & f.src_btb)
                 | (~is_redir & f.taken & ~f.src_btb);
        return {need_btb, f.is_br};
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small power-of-two FIFO with valid/ready enqueue and valid/yumi dequeue.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int unsigned ptr_w_lp = $clog2(els_p);

    logic [ptr_w_lp-1:0] rd_ptr_q, wr_ptr_q;
    logic [ptr_w_lp:0]   cnt_q;
    logic [width_p-1:0]  mem_q [els_p];
    logic                enq, deq;

    assign ready_o = (cnt_q != (ptr_w_lp+1)'(els_p));
    assign v_o     = (cnt_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because els_p is a power of two
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (enq && !deq) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (deq && !enq) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_fe_pred_update_sched.sv
// Schedules redirect and attaboy updates onto the shared BTB/BHT write ports,
// redirects first, one update in flight at a time.
module bp_fe_pred_update_sched
    import bp_fe_pkg::*;
#(
    parameter int unsigned vaddr_width_p   = 39,
    parameter int unsigned btb_tag_width_p = 10,
    parameter int unsigned btb_idx_width_p = 6,
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned ghist_width_p   = 2,
    parameter int unsigned bht_row_width_p = 8,
    parameter int unsigned fifo_els_p      = 4,
    localparam int unsigned upd_width_lp   = `BP_FE_PRED_UPD_WIDTH(vaddr_width_p,
        btb_tag_width_p, btb_idx_width_p, bht_idx_width_p, ghist_width_p, bht_row_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       init_done_i,
    input  logic                       redir_v_i,
    input  logic [upd_width_lp-1:0]    redir_upd_i,
    input  logic                       attaboy_v_i,
    input  logic [upd_width_lp-1:0]    attaboy_upd_i,
    output logic                       attaboy_yumi_o,
    output logic                       btb_w_v_o,
    output logic                       btb_w_clr_o,
    output logic                       btb_w_jmp_o,
    output logic [btb_tag_width_p-1:0] btb_w_tag_o,
    output logic [btb_idx_width_p-1:0] btb_w_idx_o,
    output logic [vaddr_width_p-1:0]   btb_w_tgt_o,
    input  logic                       btb_w_yumi_i,
    output logic                       bht_w_v_o,
    output logic [bht_idx_width_p-1:0] bht_w_idx_o,
    output logic [ghist_width_p-1:0]   bht_w_ghist_o,
    output logic [bht_row_width_p-1:0] bht_w_row_o,
    output logic                       bht_w_correct_o,
    input  logic                       bht_w_yumi_i,
    output logic                       busy_o,
    output logic [7:0]                 redir_drop_cnt_o
);
    localparam int unsigned row_lsb_lp     = 6;
    localparam int unsigned ghist_lsb_lp   = row_lsb_lp + bht_row_width_p;
    localparam int unsigned bht_idx_lsb_lp = ghist_lsb_lp + ghist_width_p;
    localparam int unsigned idx_lsb_lp     = bht_idx_lsb_lp + bht_idx_width_p;
    localparam int unsigned tag_lsb_lp     = idx_lsb_lp + btb_idx_width_p;
    localparam int unsigned tgt_lsb_lp     = tag_lsb_lp + btb_tag_width_p;

    bp_fe_pred_sched_state_e state_q;
    logic                    redir_v_q;
    logic [upd_width_lp-1:0] redir_q;
    logic [7:0]              drop_cnt_q;
    logic [upd_width_lp-1:0] cur_q;
    logic                    cur_redir_q, cur_attaboy_q;
    logic                    btb_done_q, bht_done_q;

    logic                    fifo_ready, fifo_v, fifo_enq, fifo_yumi;
    logic [upd_width_lp-1:0] fifo_data;
    logic [1:0]              attaboy_need, next_need;
    logic                    dispatch_en, take_redir_q, take_redir_i, dispatch;
    logic [upd_width_lp-1:0] next_rec;
    logic                    next_redir;
    logic                    btb_done_nxt, bht_done_nxt;

    assign attaboy_need   = pred_upd_need(1'b0, attaboy_upd_i[5:0]);
    assign attaboy_yumi_o = attaboy_v_i & fifo_ready;
    assign fifo_enq       = attaboy_yumi_o & (|attaboy_need);

    bsg_fifo_1r1w_small #(
        .width_p (upd_width_lp),
        .els_p   (fifo_els_p)
    ) u_attaboy_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (fifo_enq),
        .data_i    (attaboy_upd_i),
        .ready_o   (fifo_ready),
        .v_o       (fifo_v),
        .data_o    (fifo_data),
        .yumi_i    (fifo_yumi)
    );

    // A redirect arriving while idle with nothing held goes straight to issue.
    assign dispatch_en  = (state_q == e_idle) & init_done_i;
    assign take_redir_q = dispatch_en & redir_v_q;
    assign take_redir_i = dispatch_en & ~redir_v_q & redir_v_i;
    assign fifo_yumi    = dispatch_en & ~redir_v_q & ~redir_v_i & fifo_v;
    assign dispatch     = take_redir_q | take_redir_i | fifo_yumi;

    always_comb begin
        next_rec   = redir_q;
        next_redir = 1'b1;
        if (take_redir_i) begin
            next_rec = redir_upd_i;
        end else if (fifo_yumi) begin
            next_rec   = fifo_data;
            next_redir = 1'b0;
        end
        next_need = pred_upd_need(next_redir, next_rec[5:0]);
    end

    assign btb_done_nxt = btb_done_q | btb_w_yumi_i;
    assign bht_done_nxt = bht_done_q | bht_w_yumi_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= e_idle;
            redir_v_q     <= 1'b0;
            redir_q       <= '0;
            drop_cnt_q    <= '0;
            cur_q         <= '0;
            cur_redir_q   <= 1'b0;
            cur_attaboy_q <= 1'b0;
            btb_done_q    <= 1'b1;
            bht_done_q    <= 1'b1;
        end else begin
            if (redir_v_i && !take_redir_i) begin
                redir_q   <= redir_upd_i;
                redir_v_q <= 1'b1;
                if (redir_v_q && !take_redir_q && drop_cnt_q != 8'hff) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end else if (take_redir_q) begin
                redir_v_q <= 1'b0;
            end

            case (state_q)
                e_idle: begin
                    if (dispatch) begin
                        cur_q         <= next_rec;
                        cur_redir_q   <= next_redir;
                        cur_attaboy_q <= ~next_redir;
                        btb_done_q    <= ~next_need[1];
                        bht_done_q    <= ~next_need[0];
                        state_q       <= e_issue;
                    end
                end
                e_issue: begin
                    btb_done_q <= btb_done_nxt;
                    bht_done_q <= bht_done_nxt;
                    if (btb_done_nxt && bht_done_nxt) state_q <= e_idle;
                end
                default: state_q <= e_idle;
            endcase
        end
    end

    assign btb_w_v_o        = (state_q == e_issue) & ~btb_done_q;
    assign bht_w_v_o        = (state_q == e_issue) & ~bht_done_q;
    assign btb_w_clr_o      = cur_redir_q & cur_q[flag_nonbr_lp] & cur_q[flag_src_btb_lp];
    assign btb_w_jmp_o      = cur_q[flag_is_jmp_lp];
    assign btb_w_tag_o      = cur_q[tag_lsb_lp +: btb_tag_width_p];
    assign btb_w_idx_o      = cur_q[idx_lsb_lp +: btb_idx_width_p];
    assign btb_w_tgt_o      = cur_q[tgt_lsb_lp +: vaddr_width_p];
    assign bht_w_idx_o      = cur_q[bht_idx_lsb_lp +: bht_idx_width_p];
    assign bht_w_ghist_o    = cur_q[ghist_lsb_lp +: ghist_width_p];
    assign bht_w_row_o      = cur_q[row_lsb_lp +: bht_row_width_p];
    assign bht_w_correct_o  = cur_attaboy_q;
    assign busy_o           = (state_q == e_issue) | fifo_v | redir_v_q;
    assign redir_drop_cnt_o = drop_cnt_q;

    // Need bits are decoded at dispatch; these flags are not looked at afterwards.
    logic unused_flags;
    assign unused_flags = ^{cur_q[flag_taken_lp], cur_q[flag_ntaken_lp], cur_q[flag_is_br_lp]};

endmodule

// File: tb/tb_bp_fe_pred_update_sched.sv
// Randomised and directed bench for bp_fe_pred_update_sched against a queue-based model.
module tb_bp_fe_pred_update_sched;
    import bp_fe_pkg::*;

    localparam int unsigned UW  = $bits(bp_fe_pred_update_s);
    localparam int unsigned Els = 4;

    logic               clk_i = 1'b0;
    logic               reset_n_i, init_done_i, redir_v_i, attaboy_v_i;
    logic               btb_w_yumi_i, bht_w_yumi_i;
    bp_fe_pred_update_s redir_upd_i, attaboy_upd_i;
    logic               attaboy_yumi_o, btb_w_v_o, btb_w_clr_o, btb_w_jmp_o;
    logic [9:0]         btb_w_tag_o;
    logic [5:0]         btb_w_idx_o;
    logic [38:0]        btb_w_tgt_o;
    logic               bht_w_v_o, bht_w_correct_o, busy_o;
    logic [8:0]         bht_w_idx_o;
    logic [1:0]         bht_w_ghist_o;
    logic [7:0]         bht_w_row_o, redir_drop_cnt_o;

    always #5 clk_i = ~clk_i;

    bp_fe_pred_update_sched dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .init_done_i      (init_done_i),
        .redir_v_i        (redir_v_i),
        .redir_upd_i      (redir_upd_i),
        .attaboy_v_i      (attaboy_v_i),
        .attaboy_upd_i    (attaboy_upd_i),
        .attaboy_yumi_o   (attaboy_yumi_o),
        .btb_w_v_o        (btb_w_v_o),
        .btb_w_clr_o      (btb_w_clr_o),
        .btb_w_jmp_o      (btb_w_jmp_o),
        .btb_w_tag_o      (btb_w_tag_o),
        .btb_w_idx_o      (btb_w_idx_o),
        .btb_w_tgt_o      (btb_w_tgt_o),
        .btb_w_yumi_i     (btb_w_yumi_i),
        .bht_w_v_o        (bht_w_v_o),
        .bht_w_idx_o      (bht_w_idx_o),
        .bht_w_ghist_o    (bht_w_ghist_o),
        .bht_w_row_o      (bht_w_row_o),
        .bht_w_correct_o  (bht_w_correct_o),
        .bht_w_yumi_i     (bht_w_yumi_i),
        .busy_o           (busy_o),
        .redir_drop_cnt_o (redir_drop_cnt_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending redirect slot, attaboy queue, one update in flight
    bp_fe_pred_update_s m_q[$];
    bp_fe_pred_update_s m_redir, m_cur;
    bit m_redir_v, m_busy_wr, m_cur_redir, m_btb_left, m_bht_left;
    int m_drops;

    function automatic bit wants_btb(bit redir, bp_fe_pred_update_s u);
        if (redir) return u.flags.taken || (u.flags.nonbr && u.flags.src_btb);
        return u.flags.taken && !u.flags.src_btb;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_redir_v = 0; m_busy_wr = 0; m_btb_left = 0; m_bht_left = 0; m_drops = 0;
    endfunction

    function automatic void start(bp_fe_pred_update_s u, bit redir);
        m_cur = u; m_cur_redir = redir; m_busy_wr = 1;
        m_btb_left = wants_btb(redir, u);
        m_bht_left = u.flags.is_br;
    endfunction

    function automatic void model_step();
        bit acc, used_new;
        if (!reset_n_i) begin
            model_reset();
            return;
        end
        acc = attaboy_v_i && m_q.size() < Els;
        used_new = 0;
        if (m_busy_wr) begin
            if (btb_w_yumi_i) m_btb_left = 0;
            if (bht_w_yumi_i) m_bht_left = 0;
            if (!m_btb_left && !m_bht_left) m_busy_wr = 0;
        end else if (init_done_i) begin
            if (m_redir_v) begin
                start(m_redir, 1); m_redir_v = 0;
            end else if (redir_v_i) begin
                start(redir_upd_i, 1); used_new = 1;
            end else if (m_q.size() > 0) begin
                start(m_q.pop_front(), 0);
            end
        end
        if (redir_v_i && !used_new) begin
            if (m_redir_v && m_drops < 255) m_drops++;
            m_redir = redir_upd_i; m_redir_v = 1;
        end
        if (acc && (wants_btb(0, attaboy_upd_i) || attaboy_upd_i.flags.is_br))
            m_q.push_back(attaboy_upd_i);
    endfunction

    // Called just after a negedge with inputs applied; checks then advances one cycle
    task automatic tick();
        bit eb, eh;
        #1;
        eb = m_busy_wr && m_btb_left;
        eh = m_busy_wr && m_bht_left;
        check("btb_v", btb_w_v_o, eb);
        check("bht_v", bht_w_v_o, eh);
        check("aby_yumi", attaboy_yumi_o, attaboy_v_i && m_q.size() < Els);
        check("busy", busy_o, m_busy_wr || m_q.size() > 0 || m_redir_v);
        check("drops", redir_drop_cnt_o, m_drops);
        if (eb) begin
            check("btb_tgt", btb_w_tgt_o, m_cur.tgt);
            check("btb_tag_idx", {btb_w_tag_o, btb_w_idx_o}, {m_cur.tag, m_cur.idx});
            check("btb_clr", btb_w_clr_o, m_cur_redir && m_cur.flags.nonbr && m_cur.flags.src_btb);
            check("btb_jmp", btb_w_jmp_o, m_cur.flags.is_jmp);
        end
        if (eh) begin
            check("bht_fields", {bht_w_idx_o, bht_w_ghist_o, bht_w_row_o},
                  {m_cur.bht_idx, m_cur.ghist, m_cur.bht_row});
            check("bht_correct", bht_w_correct_o, !m_cur_redir);
        end
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic bp_fe_pred_update_s rand_rec();
        logic [95:0] raw;
        raw = {$urandom(), $urandom(), $urandom()};
        return bp_fe_pred_update_s'(raw[UW-1:0]);
    endfunction

    function automatic bp_fe_pred_update_s mk(logic [38:0] tgt, bp_fe_pred_flags_s f);
        bp_fe_pred_update_s u;
        u = rand_rec();
        u.tgt = tgt; u.flags = f;
        return u;
    endfunction

    task automatic quiet();
        redir_v_i = 0; attaboy_v_i = 0; btb_w_yumi_i = 1; bht_w_yumi_i = 1; init_done_i = 1;
        redir_upd_i = '0; attaboy_upd_i = '0;
    endtask

    task automatic drain();
        quiet();
        for (int i = 0; i < 20; i++) tick();
    endtask

    initial begin
        quiet();
        reset_n_i = 0;
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        model_reset();
        #1;
        check("rst_zero", {attaboy_yumi_o, btb_w_v_o, btb_w_clr_o, btb_w_jmp_o, bht_w_v_o,
                           bht_w_correct_o, busy_o, redir_drop_cnt_o}, '0);
        check("rst_fields", {btb_w_tag_o, btb_w_idx_o, btb_w_tgt_o}, '0);
        reset_n_i = 1;

        // Single redirect, zero-wait yumis
        redir_v_i = 1; redir_upd_i = mk(39'h8000_0100, 6'b100010);
        tick();
        redir_v_i = 0;
        check("t1_v", {btb_w_v_o, bht_w_v_o}, 2'b11);
        check("t1_tgt", btb_w_tgt_o, 39'h8000_0100);
        tick();
        check("t1_idle", {btb_w_v_o, bht_w_v_o, busy_o}, 3'b000);
        drain();

        // Fill queue while init is held off; fifth attempt must stall
        init_done_i = 0; btb_w_yumi_i = 0;
        for (int i = 0; i < 5; i++) begin
            attaboy_v_i = 1; attaboy_upd_i = mk(39'h100 + 39'(i), 6'b100000);
            if (i == 4) begin
                #1 check("t2_full", attaboy_yumi_o, 1'b0);
            end
            tick();
        end
        attaboy_v_i = 0; init_done_i = 1;
        for (int i = 0; i < 6; i++) tick();
        drain();

        // Attaboy stuck on BHT while a redirect arrives
        attaboy_v_i = 1; attaboy_upd_i = mk(39'h200, 6'b000010); bht_w_yumi_i = 0;
        tick(); attaboy_v_i = 0; tick(); tick();
        redir_v_i = 1; redir_upd_i = mk(39'h300, 6'b100000); tick();
        redir_v_i = 0; tick(); tick();
        bht_w_yumi_i = 1;
        for (int i = 0; i < 5; i++) tick();
        drain();

        // Two redirects back-to-back while busy: first one is dropped
        btb_w_yumi_i = 0; redir_v_i = 1; redir_upd_i = mk(39'h400, 6'b100000); tick();
        redir_v_i = 0; tick();
        redir_v_i = 1; redir_upd_i = mk(39'h500, 6'b100000); tick();
        redir_upd_i = mk(39'h600, 6'b100010); tick();
        redir_v_i = 0;
        check("t4_drop", redir_drop_cnt_o, 8'd1);
        btb_w_yumi_i = 1;
        for (int i = 0; i < 6; i++) tick();
        drain();

        // Clear-type redirect, then a no-op attaboy that must be discarded
        redir_v_i = 1; redir_upd_i = mk(39'h700, 6'b001100); tick();
        redir_v_i = 0;
        check("t5_clr", {btb_w_v_o, btb_w_clr_o, bht_w_v_o}, 3'b110);
        tick(); tick();
        attaboy_v_i = 1; attaboy_upd_i = mk(39'h800, 6'b000000); tick();
        attaboy_v_i = 0; tick();
        check("t5_busy", busy_o, 1'b0);
        drain();

        // Held init, then release; then reset in the middle of an issue
        init_done_i = 0; bht_w_yumi_i = 0;
        for (int i = 0; i < 2; i++) begin
            attaboy_v_i = 1; attaboy_upd_i = mk(39'h900 + 39'(i), 6'b000010); tick();
        end
        attaboy_v_i = 0; tick(); tick();
        init_done_i = 1; tick();
        check("t6_start", bht_w_v_o, 1'b1);
        tick();
        reset_n_i = 0; tick();
        reset_n_i = 1;
        check("t6_rst", {btb_w_v_o, bht_w_v_o, busy_o}, 3'b000);
        drain();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            reset_n_i    = ($urandom_range(0, 499) != 0);
            init_done_i  = ($urandom_range(0, 15) != 0);
            redir_v_i    = ($urandom_range(0, 7) == 0);
            redir_upd_i  = rand_rec();
            attaboy_v_i  = $urandom_range(0, 1);
            attaboy_upd_i = rand_rec();
            btb_w_yumi_i = ($urandom_range(0, 2) != 0);
            bht_w_yumi_i = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset_n_i = 1;
        drain();
        check("end_idle", busy_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
